// File: rtl/shift_register_if.sv
// rtl/shift_register_if.sv - shift enable, serial input and parallel output bundle
// The master drives load/load_vlaue and observes po; the shift register is the slave.
interface shift_register_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic             load_vlaue;
  logic [WIDTH-1:0] po;

  modport master (
    output load,
    output load_vlaue,
    input  po
  );

  modport slave (
    input  load,
    input  load_vlaue,
    output po
  );
endinterface

// File: rtl/shift_register.sv
// rtl/shift_register.sv - serial-in parallel-out shift register, SHIFT_AMOUNT bits per enabled edge
// Optional SHIFT_REG_ROTATE_EN: rotate instead of hold while load is low.
module shift_register #(
  parameter int    WIDTH           = 8,
  parameter string SHIFT_DIRECTION = "RIGHT",
  parameter int    SHIFT_AMOUNT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  shift_register_if.slave   bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] shift_next;
`ifdef SHIFT_REG_ROTATE_EN
  logic [WIDTH-1:0] rot_next;
`endif

  if (WIDTH < 1) begin : g_bad_width
    $error("shift_register: WIDTH must be >= 1");
  end
  if (SHIFT_DIRECTION != "RIGHT" && SHIFT_DIRECTION != "LEFT") begin : g_bad_dir
    $error("shift_register: SHIFT_DIRECTION must be \"RIGHT\" or \"LEFT\"");
  end
  if (SHIFT_AMOUNT < 1 || SHIFT_AMOUNT > WIDTH) begin : g_bad_amount
    $error("shift_register: SHIFT_AMOUNT must be within 1..WIDTH");
  end

  // A full-width shift has no surviving bits, so it cannot use the sliced forms.
  if (SHIFT_AMOUNT >= WIDTH) begin : g_full
    assign shift_next = {WIDTH{bus.load_vlaue}};
`ifdef SHIFT_REG_ROTATE_EN
    assign rot_next   = q;
`endif
  end else if (SHIFT_DIRECTION == "LEFT") begin : g_left
    assign shift_next = {q[WIDTH-1-SHIFT_AMOUNT:0], {SHIFT_AMOUNT{bus.load_vlaue}}};
`ifdef SHIFT_REG_ROTATE_EN
    assign rot_next   = {q[WIDTH-1-SHIFT_AMOUNT:0], q[WIDTH-1:WIDTH-SHIFT_AMOUNT]};
`endif
  end else begin : g_right
    assign shift_next = {{SHIFT_AMOUNT{bus.load_vlaue}}, q[WIDTH-1:SHIFT_AMOUNT]};
`ifdef SHIFT_REG_ROTATE_EN
    assign rot_next   = {q[SHIFT_AMOUNT-1:0], q[WIDTH-1:SHIFT_AMOUNT]};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (bus.load) begin
      q <= shift_next;
    end
`ifdef SHIFT_REG_ROTATE_EN
    else begin
      q <= rot_next;
    end
`endif
  end

  assign bus.po = q;

endmodule

// File: tb/tb_shift_register.sv
// tb/tb_shift_register.sv - directed self-checking bench for shift_register (RIGHT, LEFT, full-width)
module tb_shift_register;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  shift_register_if #(.WIDTH(8)) if_right ();
  shift_register_if #(.WIDTH(8)) if_left  ();
  shift_register_if #(.WIDTH(8)) if_full  ();

  shift_register #(.WIDTH(8), .SHIFT_DIRECTION("RIGHT"), .SHIFT_AMOUNT(2)) u_right (
    .clk (clk),
    .rst (rst),
    .bus (if_right)
  );

  shift_register #(.WIDTH(8), .SHIFT_DIRECTION("LEFT"), .SHIFT_AMOUNT(2)) u_left (
    .clk (clk),
    .rst (rst),
    .bus (if_left)
  );

  shift_register #(.WIDTH(8), .SHIFT_DIRECTION("RIGHT"), .SHIFT_AMOUNT(8)) u_full (
    .clk (clk),
    .rst (rst),
    .bus (if_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] right_seq [4];
  logic [7:0] hold_seq  [5];

  initial begin
    checks   = 0;
    failures = 0;
    right_seq = '{8'hC0, 8'hF0, 8'hFC, 8'hFF};
`ifdef SHIFT_REG_ROTATE_EN
    hold_seq  = '{8'h3C, 8'h0F, 8'hC3, 8'hF0, 8'h3C};
`else
    hold_seq  = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
`endif

    // Reset dominates an active load with a 1 on the serial input.
    rst = 1'b1;
    if_right.load = 1'b1; if_right.load_vlaue = 1'b1;
    if_left.load  = 1'b1; if_left.load_vlaue  = 1'b1;
    if_full.load  = 1'b1; if_full.load_vlaue  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rst_right_%0d", i), if_right.po, 8'h00);
    end
    check("rst_left", if_left.po, 8'h00);
    check("rst_full", if_full.po, 8'h00);

    rst = 1'b0;
    if_left.load = 1'b0;
    if_full.load = 1'b0;

    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("right_fill_%0d", i), if_right.po, right_seq[i]);
    end
    if_right.load_vlaue = 1'b0;
    tick();
    check("right_zero_in", if_right.po, 8'h3F);
    check("left_idle_zero", if_left.po, 8'h00);

    if_right.load = 1'b0;
    if_left.load  = 1'b1;
    tick();
    check("left_fill_0", if_left.po, 8'h03);
    tick();
    check("left_fill_1", if_left.po, 8'h0F);
    if_left.load_vlaue = 1'b0;
    tick();
    check("left_zero_in", if_left.po, 8'h3C);
    if_left.load = 1'b0;

    // Walk the right register to 8'hF0, then idle it with a toggling serial input.
    if_right.load = 1'b1;
    if_right.load_vlaue = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("right_flush", if_right.po, 8'h00);
    if_right.load_vlaue = 1'b1;
    tick();
    tick();
    check("right_f0", if_right.po, 8'hF0);
    if_right.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if_right.load_vlaue = ~if_right.load_vlaue;
      tick();
      check($sformatf("right_idle_%0d", i), if_right.po, hold_seq[i]);
    end

    // Serial input that changes and reverts between edges must not matter.
    if_right.load = 1'b1;
    if_right.load_vlaue = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if_right.load_vlaue = 1'b0;
      #2;
      if_right.load_vlaue = 1'b1;
    end
    check("right_ff", if_right.po, 8'hFF);

    // Asynchronous reset between edges.
    if_right.load = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_right", if_right.po, 8'h00);
    check("async_rst_left", if_left.po, 8'h00);
    if_right.load = 1'b1;
    tick();
    check("rst_hold_right", if_right.po, 8'h00);
    rst = 1'b0;
    tick();
    check("first_edge_after_rst", if_right.po, 8'hC0);
    if_right.load = 1'b0;

    if_full.load = 1'b1;
    if_full.load_vlaue = 1'b1;
    tick();
    check("full_ones", if_full.po, 8'hFF);
    if_full.load_vlaue = 1'b0;
    tick();
    check("full_zeros", if_full.po, 8'h00);
    if_full.load_vlaue = 1'b1;
    tick();
    check("full_ones_again", if_full.po, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
